// File: rtl/ql_bank_cfg_loader.sv
// Memory-bank configuration loader: streams one bitline word per row and pulses a one-hot wordline.
// Optional parity checking of incoming row words is enabled with `define QL_CFG_PARITY_CHECK_EN.
module ql_bank_cfg_loader #(
    parameter int BL_WIDTH  = 8,
    parameter int WL_WIDTH  = 8,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 3,
    localparam int ROW_W    = $clog2(WL_WIDTH)
) (
    input  logic                prog_clk,
    input  logic                global_resetn,
    input  logic                cfg_start,
    input  logic [BL_WIDTH-1:0] cfg_data,
    input  logic                cfg_valid,
`ifdef QL_CFG_PARITY_CHECK_EN
    input  logic                cfg_parity,
    output logic                parity_err,
`endif
    output logic                cfg_ready,
    output logic [0:BL_WIDTH-1] bl,
    output logic [0:WL_WIDTH-1] wl,
    output logic                busy,
    output logic                done,
    output logic [ROW_W-1:0]    row
);

    localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(WL_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [ROW_W-1:0]    row_r;
    logic [0:BL_WIDTH-1] bl_r;
    logic [0:WL_WIDTH-1] wl_r;
    logic                busy_r;
    logic                done_r;
`ifdef QL_CFG_PARITY_CHECK_EN
    logic                skip_r;
    logic                parity_err_r;

    function automatic logic even_parity(input logic [BL_WIDTH-1:0] data);
        return ^data;
    endfunction
`endif

    function automatic logic [0:WL_WIDTH-1] row_onehot(input logic [ROW_W-1:0] r);
        logic [0:WL_WIDTH-1] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // Programming sequencer; reset is asynchronous so wl drops immediately even mid-pulse.
    always_ff @(posedge prog_clk or negedge global_resetn) begin
        if (!global_resetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            row_r   <= '0;
            bl_r    <= '0;
            wl_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef QL_CFG_PARITY_CHECK_EN
            skip_r       <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (cfg_start) begin
                        state_r <= ST_LOAD;
                        row_r   <= '0;
                        cnt_r   <= '0;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
`ifdef QL_CFG_PARITY_CHECK_EN
                        parity_err_r <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (cfg_valid) begin
                        for (int i = 0; i < BL_WIDTH; i++) begin
                            bl_r[i] <= cfg_data[i];
                        end
                        cnt_r   <= '0;
                        state_r <= ST_SETUP;
`ifdef QL_CFG_PARITY_CHECK_EN
                        skip_r       <= (cfg_parity != even_parity(cfg_data));
                        parity_err_r <= parity_err_r | (cfg_parity != even_parity(cfg_data));
`endif
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
`ifdef QL_CFG_PARITY_CHECK_EN
                        // A row whose word failed parity keeps its timing but is never written.
                        if (skip_r) begin
                            wl_r <= '0;
                        end else begin
                            wl_r <= row_onehot(row_r);
                        end
`else
                        wl_r <= row_onehot(row_r);
`endif
                        cnt_r   <= '0;
                        state_r <= ST_PULSE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == PULSE_LAST) begin
                        wl_r    <= '0;
                        cnt_r   <= '0;
                        state_r <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (row_r == ROW_LAST) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        row_r   <= row_r + 1'b1;
                        state_r <= ST_LOAD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    wl_r    <= '0;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = (state_r == ST_LOAD);
    assign bl        = bl_r;
    assign wl        = wl_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign row       = row_r;
`ifdef QL_CFG_PARITY_CHECK_EN
    assign parity_err = parity_err_r;
`endif

endmodule
